// File: rtl/cntr8_ctrl_pkg.sv
// Shared opcode constants, FSM state encodings and the latched command record
// for the two-requester 8-bit counter controller.
package cntr8_ctrl_pkg;

  localparam logic [1:0] OP_READ = 2'b00;
  localparam logic [1:0] OP_INC  = 2'b01;
  localparam logic [1:0] OP_LOAD = 2'b10;
  localparam logic [1:0] OP_STEP = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE = 3'b000,
    ST_LOAD = 3'b001,
    ST_INC  = 3'b010,
    ST_STEP = 3'b011,
    ST_DONE = 3'b100
  } state_e;

  // The opcode is carried by the FSM state itself, so only id and arg are kept.
  typedef struct packed {
    logic       id;
    logic [7:0] arg;
  } cmd_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: combinational winner select plus a 1-bit
// priority pointer that hands priority to the requester not served last.
module rr_arb2 (
  input  logic clk,
  input  logic reset_n,
  input  logic req0,
  input  logic req1,
  input  logic grant_en,
  input  logic upd_en,
  output logic win_id,
  output logic win_valid
);

  logic ptr;
  logic gnt_id;

  assign win_valid = req0 | req1;
  assign win_id    = (req0 & req1) ? ptr : req1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr    <= 1'b0;
      gnt_id <= 1'b0;
    end else begin
      if (grant_en) gnt_id <= win_id;
      if (upd_en)   ptr    <= ~gnt_id;
    end
  end

endmodule

// File: rtl/cntr8_ctrl.sv
// Command controller for an external 8-bit counter: arbitrates two requesters
// and sequences READ / INC / LOAD / STEP into inc/load pulses with an ack.
module cntr8_ctrl
  import cntr8_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req0,
  input  logic       req1,
  input  logic [1:0] op0,
  input  logic [1:0] op1,
  input  logic [7:0] arg0,
  input  logic [7:0] arg1,
  output logic       ack0,
  output logic       ack1,
  output logic [7:0] result,
  output logic       busy,
  output logic       cnt_inc,
  output logic       cnt_load,
  output logic [7:0] cnt_d_in,
  input  logic [7:0] cnt_q,
  output logic [2:0] o_state
);

  state_e     state, state_nxt;
  cmd_t       cmd_q;
  logic [7:0] rem_q;
  logic       win_id, win_valid;
  logic       grant_en, upd_en;
  logic [1:0] sel_op;
  logic [7:0] sel_arg;

  assign grant_en = (state == ST_IDLE) && win_valid;
  assign upd_en   = (state == ST_DONE);
  assign sel_op   = win_id ? op1  : op0;
  assign sel_arg  = win_id ? arg1 : arg0;
  assign busy     = (state != ST_IDLE);
  assign o_state  = state;

  rr_arb2 u_arb (
    .clk       (clk),
    .reset_n   (reset_n),
    .req0      (req0),
    .req1      (req1),
    .grant_en  (grant_en),
    .upd_en    (upd_en),
    .win_id    (win_id),
    .win_valid (win_valid)
  );

  always_comb begin
    state_nxt = state;
    cnt_inc   = 1'b0;
    cnt_load  = 1'b0;
    cnt_d_in  = 8'h00;
    ack0      = 1'b0;
    ack1      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (win_valid) begin
          case (sel_op)
            OP_READ: state_nxt = ST_DONE;
            OP_INC:  state_nxt = ST_INC;
            OP_LOAD: state_nxt = ST_LOAD;
            default: state_nxt = (sel_arg == 8'h00) ? ST_DONE : ST_STEP;
          endcase
        end
      end
      ST_LOAD: begin
        cnt_load  = 1'b1;
        cnt_d_in  = cmd_q.arg;
        state_nxt = ST_DONE;
      end
      ST_INC: begin
        cnt_inc   = 1'b1;
        state_nxt = ST_DONE;
      end
      ST_STEP: begin
        cnt_inc = 1'b1;
        if (rem_q == 8'd1) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        ack0      = ~cmd_q.id;
        ack1      = cmd_q.id;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= ST_IDLE;
      cmd_q  <= '0;
      rem_q  <= 8'h00;
      result <= 8'h00;
    end else begin
      state <= state_nxt;
      if (grant_en) begin
        cmd_q.id  <= win_id;
        cmd_q.arg <= sel_arg;
        if (sel_op == OP_STEP) rem_q <= sel_arg;
      end else if (state == ST_STEP) begin
        rem_q <= rem_q - 8'd1;
      end
      // Pulses issued up to the previous cycle are already visible on cnt_q here.
      if (state == ST_DONE) result <= cnt_q;
    end
  end

endmodule

// File: tb/tb_cntr8_ctrl.sv
// Self-checking bench for cntr8_ctrl: directed scenarios plus randomized
// two-requester traffic checked against an abstract command-level model.
module tb_cntr8_ctrl;
  import cntr8_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [1:0] op0 = 2'b00, op1 = 2'b00;
  logic [7:0] arg0 = 8'h00, arg1 = 8'h00;
  logic       ack0, ack1, busy, cnt_inc, cnt_load;
  logic [7:0] result, cnt_d_in;
  logic [7:0] cnt_q = 8'h00;
  logic [2:0] o_state;

  int checks = 0;
  int errors = 0;

  logic [7:0] mdl_cnt = 8'h00;
  bit         mdl_ptr = 1'b0;

  logic [1:0] g_op0[$], g_op1[$];
  logic [7:0] g_arg0[$], g_arg1[$];
  int         obs_id[$], obs_t[$];
  logic [7:0] obs_res[$];
  int         obs_viol;
  bit         obs_tmo;

  always #5 clk = ~clk;

  // External 8-bit counter the controller drives.
  always @(posedge clk) begin
    if (cnt_load)     cnt_q <= cnt_d_in;
    else if (cnt_inc) cnt_q <= cnt_q + 8'd1;
  end

  cntr8_ctrl dut (
    .clk(clk), .reset_n(reset_n),
    .req0(req0), .req1(req1), .op0(op0), .op1(op1), .arg0(arg0), .arg1(arg1),
    .ack0(ack0), .ack1(ack1), .result(result), .busy(busy),
    .cnt_inc(cnt_inc), .cnt_load(cnt_load), .cnt_d_in(cnt_d_in),
    .cnt_q(cnt_q), .o_state(o_state)
  );

  task automatic do_reset();
    reset_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0;
    repeat (2) @(negedge clk);
    #1 reset_n = 1'b1;
  endtask

  // Issues one command from one requester and measures what the DUT does.
  task automatic run_cmd(input bit id, input logic [1:0] op, input logic [7:0] arg,
                         output int lat, output int incs, output int loads,
                         output logic [7:0] dval, output logic [7:0] res,
                         output int acks, output int viol);
    int k;
    bit done;
    lat = -1; incs = 0; loads = 0; dval = 8'h00; acks = 0; viol = 0; done = 0; k = 0;
    @(posedge clk); #1;
    if (id) begin req1 = 1'b1; op1 = op; arg1 = arg; end
    else    begin req0 = 1'b1; op0 = op; arg0 = arg; end
    while (!done && k < 600) begin
      @(negedge clk);
      if (cnt_inc && cnt_load) viol++;
      if (busy !== (o_state != 3'd0)) viol++;
      if (!cnt_load && cnt_d_in != 8'h00) viol++;
      if (id ? ack0 : ack1) viol++;
      if (cnt_inc) incs++;
      if (cnt_load) begin loads++; dval = cnt_d_in; end
      if (id ? ack1 : ack0) begin lat = k; acks++; done = 1; end
      k++;
    end
    @(posedge clk); #1;
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    res = result;
    if (ack0 || ack1) acks++;
  endtask

  task automatic drive_reqs(input int p0, input int p1);
    req0 = (p0 < g_op0.size());
    op0  = req0 ? g_op0[p0]  : 2'b00;
    arg0 = req0 ? g_arg0[p0] : 8'h00;
    req1 = (p1 < g_op1.size());
    op1  = req1 ? g_op1[p1]  : 2'b00;
    arg1 = req1 ? g_arg1[p1] : 8'h00;
  endtask

  // Both requesters work through their command queues, re-presenting in the
  // cycle after each ack; records ack order, ack sample index and results.
  task automatic run_multi();
    int p0, p1, t;
    bit pend_res;
    p0 = 0; p1 = 0; t = 0; pend_res = 0;
    obs_id.delete(); obs_t.delete(); obs_res.delete(); obs_viol = 0;
    @(posedge clk); #1;
    drive_reqs(p0, p1);
    while ((p0 < g_op0.size() || p1 < g_op1.size() || pend_res) && t < 4000) begin
      @(negedge clk);
      if (pend_res) begin obs_res.push_back(result); pend_res = 0; end
      if ((cnt_inc && cnt_load) || (busy !== (o_state != 3'd0)) ||
          (!cnt_load && cnt_d_in != 8'h00) || (ack0 && ack1)) obs_viol++;
      if (ack0 ^ ack1) begin
        obs_id.push_back(ack1 ? 1 : 0);
        obs_t.push_back(t);
        pend_res = 1;
        if (ack1) p1++; else p0++;
      end
      t++;
      @(posedge clk); #1;
      drive_reqs(p0, p1);
    end
    obs_tmo = (t >= 4000);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({ack0, ack1, busy, cnt_inc, cnt_load} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl ack0/ack1/busy/inc/load=%b want 00000", {ack0, ack1, busy, cnt_inc, cnt_load});
    end
    checks++;
    if (o_state !== 3'd0 || result !== 8'h00 || cnt_d_in !== 8'h00) begin
      errors++; $display("FAIL reset_data state=%0d result=%h d_in=%h want 0/00/00", o_state, result, cnt_d_in);
    end
    #1 reset_n = 1'b1;
  endtask

  task automatic test_load();
    int lat, incs, loads, acks, viol;
    logic [7:0] dval, res;
    run_cmd(1'b0, OP_LOAD, 8'h5A, lat, incs, loads, dval, res, acks, viol);
    checks++; if (loads !== 1 || incs !== 0) begin errors++; $display("FAIL load_pulses loads=%0d incs=%0d want 1/0", loads, incs); end
    checks++; if (dval !== 8'h5A) begin errors++; $display("FAIL load_data got %h want 5a", dval); end
    checks++; if (lat !== 2 || acks !== 1) begin errors++; $display("FAIL load_ack lat=%0d acks=%0d want 2/1", lat, acks); end
    checks++; if (res !== 8'h5A) begin errors++; $display("FAIL load_result got %h want 5a", res); end
    checks++; if (viol !== 0) begin errors++; $display("FAIL load_invariant violations=%0d want 0", viol); end
    mdl_cnt = 8'h5A; mdl_ptr = 1'b1;
  endtask

  task automatic test_step_wrap();
    int lat, incs, loads, acks, viol;
    logic [7:0] dval, res;
    run_cmd(1'b1, OP_LOAD, 8'hFE, lat, incs, loads, dval, res, acks, viol);
    checks++; if (res !== 8'hFE) begin errors++; $display("FAIL preload_fe got %h want fe", res); end
    run_cmd(1'b1, OP_STEP, 8'd3, lat, incs, loads, dval, res, acks, viol);
    checks++; if (incs !== 3 || loads !== 0) begin errors++; $display("FAIL step3_pulses incs=%0d loads=%0d want 3/0", incs, loads); end
    checks++; if (lat !== 4 || acks !== 1) begin errors++; $display("FAIL step3_ack lat=%0d acks=%0d want 4/1", lat, acks); end
    checks++; if (res !== 8'h01) begin errors++; $display("FAIL step3_wrap got %h want 01", res); end
    run_cmd(1'b0, OP_STEP, 8'd255, lat, incs, loads, dval, res, acks, viol);
    checks++; if (incs !== 255 || lat !== 256) begin errors++; $display("FAIL step255 incs=%0d lat=%0d want 255/256", incs, lat); end
    checks++; if (res !== 8'h00 || viol !== 0) begin errors++; $display("FAIL step255_result got %h viol=%0d want 00/0", res, viol); end
    mdl_cnt = 8'h00; mdl_ptr = 1'b1;
  endtask

  task automatic test_zero_pulse();
    int lat, incs, loads, acks, viol;
    logic [7:0] dval, res;
    run_cmd(1'b0, OP_INC, 8'($urandom), lat, incs, loads, dval, res, acks, viol);
    checks++; if (incs !== 1 || lat !== 2 || res !== 8'h01) begin errors++; $display("FAIL inc incs=%0d lat=%0d res=%h want 1/2/01", incs, lat, res); end
    run_cmd(1'b0, OP_STEP, 8'd0, lat, incs, loads, dval, res, acks, viol);
    checks++; if (incs !== 0 || loads !== 0 || lat !== 1) begin errors++; $display("FAIL step0 incs=%0d loads=%0d lat=%0d want 0/0/1", incs, loads, lat); end
    checks++; if (res !== 8'h01) begin errors++; $display("FAIL step0_result got %h want 01", res); end
    run_cmd(1'b1, OP_READ, 8'($urandom), lat, incs, loads, dval, res, acks, viol);
    checks++; if (incs !== 0 || loads !== 0 || lat !== 1) begin errors++; $display("FAIL read incs=%0d loads=%0d lat=%0d want 0/0/1", incs, loads, lat); end
    checks++; if (res !== 8'h01 || viol !== 0) begin errors++; $display("FAIL read_result got %h viol=%0d want 01/0", res, viol); end
    mdl_cnt = 8'h01; mdl_ptr = 1'b0;
  endtask

  task automatic test_reset_abort();
    int lat, incs, loads, acks, viol, n_inc, n_ack;
    logic [7:0] dval, res;
    @(posedge clk); #1;
    req0 = 1'b1; op0 = OP_STEP; arg0 = 8'd10;
    repeat (5) @(negedge clk);
    checks++; if (cnt_inc !== 1'b1) begin errors++; $display("FAIL abort_pre_inc got %b want 1", cnt_inc); end
    #1 reset_n = 1'b0;
    #1;
    checks++;
    if (cnt_inc !== 1'b0 || busy !== 1'b0 || o_state !== 3'd0 || ack0 !== 1'b0) begin
      errors++; $display("FAIL abort_immediate inc=%b busy=%b state=%0d ack0=%b want 0/0/0/0", cnt_inc, busy, o_state, ack0);
    end
    req0 = 1'b0;
    n_inc = 0; n_ack = 0;
    repeat (3) begin @(negedge clk); if (cnt_inc) n_inc++; if (ack0 || ack1) n_ack++; end
    #1 reset_n = 1'b1;
    repeat (3) begin @(negedge clk); if (cnt_inc) n_inc++; if (ack0 || ack1 || busy) n_ack++; end
    checks++; if (n_inc !== 0 || n_ack !== 0) begin errors++; $display("FAIL abort_quiet incs=%0d ack_or_busy=%0d want 0/0", n_inc, n_ack); end
    run_cmd(1'b0, OP_LOAD, 8'h33, lat, incs, loads, dval, res, acks, viol);
    checks++; if (lat !== 2 || loads !== 1 || dval !== 8'h33 || res !== 8'h33) begin
      errors++; $display("FAIL abort_reload lat=%0d loads=%0d d=%h res=%h want 2/1/33/33", lat, loads, dval, res);
    end
    mdl_cnt = 8'h33;
  endtask

  task automatic test_arbitration();
    do_reset();
    g_op0 = '{OP_INC, OP_INC}; g_arg0 = '{8'h00, 8'h00};
    g_op1 = '{OP_INC};         g_arg1 = '{8'h00};
    run_multi();
    checks++;
    if (obs_tmo || obs_id.size() != 3) begin
      errors++; $display("FAIL arb_count acks=%0d timeout=%0d want 3/0", obs_id.size(), obs_tmo);
    end else begin
      checks++; if (obs_id[0] != 0 || obs_id[1] != 1 || obs_id[2] != 0) begin
        errors++; $display("FAIL arb_order got %0d,%0d,%0d want 0,1,0", obs_id[0], obs_id[1], obs_id[2]);
      end
      // INC takes 2 cycles to ack, plus exactly one IDLE cycle between commands.
      checks++; if (obs_t[0] != 2 || obs_t[1] != 5 || obs_t[2] != 8) begin
        errors++; $display("FAIL arb_timing got %0d,%0d,%0d want 2,5,8", obs_t[0], obs_t[1], obs_t[2]);
      end
      checks++; if (obs_res[0] !== 8'h34 || obs_res[1] !== 8'h35 || obs_res[2] !== 8'h36) begin
        errors++; $display("FAIL arb_results got %h,%h,%h want 34,35,36", obs_res[0], obs_res[1], obs_res[2]);
      end
    end
    checks++; if (obs_viol != 0) begin errors++; $display("FAIL arb_invariant violations=%0d want 0", obs_viol); end
    mdl_cnt = 8'h36; mdl_ptr = 1'b1;
  endtask

  task automatic test_random();
    for (int trial = 0; trial < 30; trial++) begin
      int n0, n1, q0, q1, lat, prev;
      bit w, ptr;
      logic [1:0] op;
      logic [7:0] a;
      int exp_id[$], exp_t[$];
      logic [7:0] exp_res[$];
      g_op0.delete(); g_arg0.delete(); g_op1.delete(); g_arg1.delete();
      n0 = $urandom_range(0, 3); n1 = $urandom_range(0, 3);
      if (n0 == 0 && n1 == 0) n0 = 1;
      for (int i = 0; i < n0 + n1; i++) begin
        op = 2'($urandom_range(0, 3));
        a  = (op == OP_STEP) ? 8'($urandom_range(0, 15)) : 8'($urandom);
        if (i < n0) begin g_op0.push_back(op); g_arg0.push_back(a); end
        else        begin g_op1.push_back(op); g_arg1.push_back(a); end
      end
      ptr = mdl_ptr; q0 = 0; q1 = 0; prev = -1;
      while (q0 < n0 || q1 < n1) begin
        w  = (q0 < n0 && q1 < n1) ? ptr : (q0 < n0 ? 1'b0 : 1'b1);
        op = w ? g_op1[q1]  : g_op0[q0];
        a  = w ? g_arg1[q1] : g_arg0[q0];
        case (op)
          OP_READ: lat = 1;
          OP_INC:  begin lat = 2; mdl_cnt = mdl_cnt + 8'd1; end
          OP_LOAD: begin lat = 2; mdl_cnt = a; end
          default: begin lat = (a == 8'd0) ? 1 : int'(a) + 1; mdl_cnt = mdl_cnt + a; end
        endcase
        prev = prev + 1 + lat;
        exp_id.push_back(int'(w)); exp_t.push_back(prev); exp_res.push_back(mdl_cnt);
        ptr = ~w;
        if (w) q1++; else q0++;
      end
      mdl_ptr = ptr;
      run_multi();
      checks++;
      if (obs_tmo || obs_id.size() != exp_id.size()) begin
        errors++; $display("FAIL rand%0d_count acks=%0d timeout=%0d want %0d/0", trial, obs_id.size(), obs_tmo, exp_id.size());
      end else begin
        for (int i = 0; i < exp_id.size(); i++) begin
          checks++; if (obs_id[i] != exp_id[i]) begin errors++; $display("FAIL rand%0d_order[%0d] got %0d want %0d", trial, i, obs_id[i], exp_id[i]); end
          checks++; if (obs_t[i] != exp_t[i]) begin errors++; $display("FAIL rand%0d_time[%0d] got %0d want %0d", trial, i, obs_t[i], exp_t[i]); end
          checks++; if (obs_res[i] !== exp_res[i]) begin errors++; $display("FAIL rand%0d_result[%0d] got %h want %h", trial, i, obs_res[i], exp_res[i]); end
        end
      end
      checks++; if (obs_viol != 0) begin errors++; $display("FAIL rand%0d_invariant violations=%0d want 0", trial, obs_viol); end
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_step_wrap();
    test_zero_pulse();
    test_reset_abort();
    test_arbitration();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
